// File: rtl/wb_pkg.sv
// Shared Wishbone widths and the initiator state encoding.
package wb_pkg;
    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;
endpackage

// File: rtl/wb_initiator.sv
// Single-transaction Wishbone classic initiator: one command in, one bus cycle
// (ack or timeout), one response out.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic                i_cmd_we,
    input  logic [WB_ADR_W-1:0] i_cmd_adr,
    input  logic [WB_DAT_W-1:0] i_cmd_dat,
    input  logic [WB_SEL_W-1:0] i_cmd_sel,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic [WB_DAT_W-1:0] o_rsp_dat,
    output logic                o_rsp_err,
    output logic [WB_ADR_W-1:0] o_wb_adr,
    output logic [WB_DAT_W-1:0] o_wb_dat,
    output logic [WB_SEL_W-1:0] o_wb_sel,
    output logic                o_wb_we,
    output logic                o_wb_cyc,
    output logic                o_wb_stb,
    input  logic [WB_DAT_W-1:0] i_wb_dat,
    input  logic                i_wb_ack
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid source holds its payload stable until that edge.

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    wb_state_e state, state_d;
    logic [TW-1:0] timer, timer_d;

    logic [WB_ADR_W-1:0] wb_adr_d;
    logic [WB_DAT_W-1:0] wb_dat_d;
    logic [WB_SEL_W-1:0] wb_sel_d;
    logic                wb_we_d;
    logic                wb_cyc_d;
    logic                rsp_valid_d;
    logic [WB_DAT_W-1:0] rsp_dat_d;
    logic                rsp_err_d;

    logic timed_out;
    assign timed_out   = (timer == TIMER_LAST);
    assign o_cmd_ready = (state == IDLE);
    assign o_wb_stb    = o_wb_cyc;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            timer       <= '0;
            o_wb_adr    <= '0;
            o_wb_dat    <= '0;
            o_wb_sel    <= '0;
            o_wb_we     <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_dat   <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            state       <= state_d;
            timer       <= timer_d;
            o_wb_adr    <= wb_adr_d;
            o_wb_dat    <= wb_dat_d;
            o_wb_sel    <= wb_sel_d;
            o_wb_we     <= wb_we_d;
            o_wb_cyc    <= wb_cyc_d;
            o_rsp_valid <= rsp_valid_d;
            o_rsp_dat   <= rsp_dat_d;
            o_rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (i_cmd_valid) state_d = BUS;
            BUS:     if (i_wb_ack || timed_out) state_d = RESP;
            RESP:    if (i_rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cyc/stb drop on the very edge that samples ack, so a responder that
    // gates its strobe detection on its own ack never sees a second strobe.
    always_comb begin
        timer_d     = timer;
        wb_adr_d    = o_wb_adr;
        wb_dat_d    = o_wb_dat;
        wb_sel_d    = o_wb_sel;
        wb_we_d     = o_wb_we;
        wb_cyc_d    = o_wb_cyc;
        rsp_valid_d = o_rsp_valid;
        rsp_dat_d   = o_rsp_dat;
        rsp_err_d   = o_rsp_err;
        case (state)
            IDLE: begin
                if (i_cmd_valid) begin
                    wb_adr_d = i_cmd_adr;
                    wb_dat_d = i_cmd_dat;
                    wb_sel_d = i_cmd_sel;
                    wb_we_d  = i_cmd_we;
                    wb_cyc_d = 1'b1;
                    timer_d  = '0;
                end
            end
            BUS: begin
                if (i_wb_ack) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = o_wb_we ? '0 : i_wb_dat;
                    rsp_err_d   = 1'b0;
                end else if (timed_out) begin
                    wb_cyc_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            RESP: begin
                if (i_rsp_ready) rsp_valid_d = 1'b0;
            end
            default: begin
                wb_cyc_d    = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end
endmodule
